loop_bracket_seeker: RTL and testbench

- Sequencer directly upstream of the instruction-pointer counter (IP, an instance of the counter block).
- Executes the Brainfuck bracket skip: on '[' with zero data it steps IP forward to the matching ']'. On ']' with non-zero data it steps IP backward to the matching '['.
- Drives the counter's Request/Dec handshake and consumes its Ready.
- Reads the instruction fetched at each new IP and tracks nesting depth until the match is found.

---
 rtl/dekatron_pkg.sv | 15 +
 rtl/loop_bracket_seeker.sv | 118 +++++++++++
 tb/tb_loop_bracket_seeker.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dekatron_pkg.sv
// Shared definitions for the dekatron Brainfuck datapath: instruction codes and
// the bracket-seeker state encoding.
package dekatron_pkg;

  localparam logic [3:0] INSN_LOOP_OPEN  = 4'h6;
  localparam logic [3:0] INSN_LOOP_CLOSE = 4'h7;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StGuard,
    StWait
  } seek_state_e;

endpackage

// File: rtl/loop_bracket_seeker.sv
// Walks the instruction pointer forward or backward, one counter step at a time,
// until the bracket matching the one at the starting IP is reached.
module loop_bracket_seeker
  import dekatron_pkg::*;
#(
  parameter int unsigned INSN_WIDTH  = 4,
  parameter int unsigned DEPTH_WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Start,
  input  logic                   Backward,
  input  logic [INSN_WIDTH-1:0]  Insn,
  input  logic                   IpReady,
  output logic                   IpRequest,
  output logic                   IpDec,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [DEPTH_WIDTH-1:0] Depth
);

  seek_state_e            r_state;
  logic                   r_dir;
  logic [DEPTH_WIDTH-1:0] r_depth;
  logic                   r_req;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic w_is_open;
  logic w_is_close;
  logic w_same_dir;
  logic w_closing;
  logic w_depth_max;
  logic w_depth_last;

  assign w_is_open    = (Insn == INSN_WIDTH'(INSN_LOOP_OPEN));
  assign w_is_close   = (Insn == INSN_WIDTH'(INSN_LOOP_CLOSE));
  // A bracket pointing the same way as the seek nests deeper; the opposite one unwinds.
  assign w_same_dir   = r_dir ? w_is_close : w_is_open;
  assign w_closing    = r_dir ? w_is_open : w_is_close;
  assign w_depth_max  = &r_depth;
  assign w_depth_last = (r_depth == DEPTH_WIDTH'(1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= StIdle;
      r_dir   <= 1'b0;
      r_depth <= '0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        StIdle: begin
          if (Start) begin
            r_dir   <= Backward;
            r_depth <= DEPTH_WIDTH'(1);
            r_busy  <= 1'b1;
            r_state <= StReq;
          end
        end
        StReq: begin
          if (IpReady) begin
            r_req   <= 1'b1;
            r_state <= StGuard;
          end
        end
        // Ready is only masked by Request during the pulse itself; skip this cycle.
        StGuard: begin
          r_state <= StWait;
        end
        StWait: begin
          if (IpReady) begin
            if (w_same_dir) begin
              if (w_depth_max) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
                r_depth <= '0;
                r_state <= StIdle;
              end else begin
                r_depth <= r_depth + DEPTH_WIDTH'(1);
                r_state <= StReq;
              end
            end else if (w_closing) begin
              r_depth <= r_depth - DEPTH_WIDTH'(1);
              if (w_depth_last) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end else begin
                r_state <= StReq;
              end
            end else begin
              r_state <= StReq;
            end
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign IpRequest = r_req;
  assign IpDec     = r_dir;
  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Error     = r_error;
  assign Depth     = r_depth;

endmodule

// File: tb/tb_loop_bracket_seeker.sv
// Scoreboard bench: a behavioural IP counter with a 3-cycle step delay drives the
// seeker; each seek queues its expected outcome and a monitor checks every pulse/end.
module tb_loop_bracket_seeker;

  localparam int unsigned IW = 4;
  localparam int unsigned DW = 2;
  localparam int unsigned COUNT_DELAY = 3;

  typedef struct {
    bit          err;
    logic [3:0]  ip;
    int          pulses;
    bit          dir;
    int          max_depth;
  } exp_t;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic          Backward = 1'b0;
  logic [IW-1:0] Insn;
  logic          IpReady;
  logic          IpRequest;
  logic          IpDec;
  logic          Busy;
  logic          Done;
  logic          Error;
  logic [DW-1:0] Depth;

  logic [3:0] prog [16];
  logic [3:0] ip = '0;
  int         cnt = 0;
  logic       hold = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] ld_val = '0;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 Clk = ~Clk;

  loop_bracket_seeker #(
    .INSN_WIDTH (IW),
    .DEPTH_WIDTH(DW)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Start    (Start),
    .Backward (Backward),
    .Insn     (Insn),
    .IpReady  (IpReady),
    .IpRequest(IpRequest),
    .IpDec    (IpDec),
    .Busy     (Busy),
    .Done     (Done),
    .Error    (Error),
    .Depth    (Depth)
  );

  // IP counter model: steps on a sampled Request, then stays not-ready for COUNT_DELAY cycles.
  always @(posedge Clk) begin
    if (ld) begin
      ip  <= ld_val;
      cnt <= 0;
    end else if (IpRequest) begin
      ip  <= IpDec ? ip - 4'd1 : ip + 4'd1;
      cnt <= COUNT_DELAY;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign IpReady = (cnt == 0) && !IpRequest && !hold;
  assign Insn    = prog[ip];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input string s);
    for (int i = 0; i < 16; i++) prog[i] = 4'h0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "[":     prog[i] = 4'h6;
        "]":     prog[i] = 4'h7;
        "+":     prog[i] = 4'h2;
        "-":     prog[i] = 4'h3;
        default: prog[i] = 4'h0;
      endcase
    end
  endtask

  task automatic set_ip(input logic [3:0] v);
    @(negedge Clk);
    ld_val = v;
    ld     = 1'b1;
    @(negedge Clk);
    ld     = 1'b0;
  endtask

  task automatic expect_seek(input bit err, input logic [3:0] eip, input int pulses,
                             input bit dir, input int maxd);
    exp_t e;
    e.err       = err;
    e.ip        = eip;
    e.pulses    = pulses;
    e.dir       = dir;
    e.max_depth = maxd;
    sb.push_back(e);
  endtask

  task automatic start_seek(input bit back);
    @(negedge Clk);
    Start    = 1'b1;
    Backward = back;
    @(negedge Clk);
    Start    = 1'b0;
    Backward = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || Busy) && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check("seek_timeout", 32'(n < budget), 32'd1);
    repeat (3) @(negedge Clk);
  endtask

  // Monitor: per-pulse direction/shape checks and end-of-seek scoreboard compare.
  initial begin
    bit prev_req = 1'b0;
    int pulses = 0;
    int maxd = 0;
    bit prev_busy = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        prev_req  = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (Busy && !prev_busy) begin
          pulses = 0;
          maxd   = 0;
        end
        if (Busy && int'(Depth) > maxd) maxd = int'(Depth);
        if (IpRequest) begin
          pulses++;
          check("req_single_cycle", 32'(prev_req), 32'd0);
          if (sb.size() > 0) check("ipdec_dir", 32'(IpDec), 32'(sb[0].dir));
        end
        if (Done || Error) begin
          check("busy_with_end", 32'(Busy), 32'd0);
          if (sb.size() == 0) begin
            check("unexpected_end", 32'({Done, Error}), 32'd0);
          end else begin
            e = sb.pop_front();
            check("end_kind", 32'({Done, Error}), 32'({~e.err, e.err}));
            check("end_ip", 32'(ip), 32'(e.ip));
            check("end_pulses", 32'(pulses), 32'(e.pulses));
            check("end_max_depth", 32'(maxd), 32'(e.max_depth));
            check("end_depth", 32'(Depth), 32'd0);
          end
        end
        prev_req  = IpRequest;
        prev_busy = Busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    load("");
    repeat (3) @(negedge Clk);
    check("reset_outputs", 32'({IpRequest, IpDec, Busy, Done, Error, Depth}), 32'd0);
    Rst_n = 1'b1;

    // Forward "[+-]": three steps, depth stays 1 until the final ']'.
    load("[+-]");
    set_ip(4'd0);
    expect_seek(1'b0, 4'd3, 3, 1'b0, 1);
    start_seek(1'b0);
    wait_idle(200);

    // Backward through "[[+]-]" from the last ']'.
    load("[[+]-]");
    set_ip(4'd5);
    expect_seek(1'b0, 4'd0, 5, 1'b1, 2);
    start_seek(1'b1);
    wait_idle(300);

    // Counter not ready for 10 cycles: no request until Ready rises.
    load("[+-]");
    set_ip(4'd0);
    hold = 1'b1;
    expect_seek(1'b0, 4'd3, 3, 1'b0, 1);
    start_seek(1'b0);
    for (int i = 0; i < 10; i++) begin
      check("hs_no_request", 32'(IpRequest), 32'd0);
      @(negedge Clk);
    end
    hold = 1'b0;
    @(negedge Clk);
    check("hs_first_pulse", 32'(IpRequest), 32'd1);
    wait_idle(200);

    // Depth overflow with DEPTH_WIDTH=2: fourth '[' would need depth 4.
    load("[[[[");
    set_ip(4'd0);
    expect_seek(1'b1, 4'd3, 3, 1'b0, 3);
    start_seek(1'b0);
    wait_idle(200);

    // Reset mid-seek while waiting on the counter at depth 2.
    load("[[+]]");
    set_ip(4'd4);
    start_seek(1'b1);
    n = 0;
    while (Depth != DW'(2) && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("rst_depth_reached", 32'(Depth), 32'd2);
    n = 0;
    while (!IpRequest && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("rst_pulse_seen", 32'(IpRequest), 32'd1);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    check("rst_mid_outputs", 32'({IpRequest, IpDec, Busy, Done, Error, Depth}), 32'd0);
    Rst_n = 1'b1;
    load("[+-]");
    set_ip(4'd0);
    expect_seek(1'b0, 4'd3, 3, 1'b0, 1);
    start_seek(1'b0);
    wait_idle(200);

    // Start (with Backward=1) during a seek must be ignored.
    load("[+-]");
    set_ip(4'd0);
    expect_seek(1'b0, 4'd3, 3, 1'b0, 1);
    start_seek(1'b0);
    repeat (2) @(negedge Clk);
    Start    = 1'b1;
    Backward = 1'b1;
    @(negedge Clk);
    Start    = 1'b0;
    Backward = 1'b0;
    wait_idle(200);
    repeat (20) @(negedge Clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("idle_after_seek", 32'({Busy, Depth}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
